// File: rtl/transport_receive.sv
// Receive-side transport: frames the incoming byte stream into packetSize-byte packets,
// decodes control/audio headers and strobes 16-bit words upward. Optional macro: RX_TRAILER_CHECK_EN.
module transport_receive #(
    parameter int packetSize = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  packetIn,
    input  logic        receiving,
    output logic [1:0]  cmd,
    output logic [15:0] data,
    output logic        dataReady,
    output logic        busy,
    output logic        error
);
    localparam int CW = $clog2(packetSize) + 1;
    localparam logic [CW-1:0] LAST   = CW'(packetSize - 1);
    localparam logic [CW-1:0] PENULT = CW'(packetSize - 2);

    typedef enum logic [2:0] {IDLE, CTRL_HI, CTRL_LO, AUD_HI, AUD_LO, TRAIL, SKIP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   byteCnt_q, byteCnt_d;
    logic [7:0]      hi_q, hi_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [15:0]     data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;
    logic            pktEnd_q, pktEnd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            byteCnt_q <= '0;
            hi_q      <= '0;
            cmd_q     <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            pktEnd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            pktEnd_q  <= pktEnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        pktEnd_d  = 1'b0;

        if (state_q == IDLE) begin
            if (receiving) begin
                byteCnt_d = CW'(1);
                case (packetIn)
                    8'h40:   state_d = CTRL_HI;
                    8'h81:   state_d = AUD_HI;
                    default: begin
                        state_d = SKIP;
                        err_d   = 1'b1;
                    end
                endcase
            end
        end else if (!receiving) begin
            // Framing dropped mid-packet: discard any half-assembled word.
            state_d   = IDLE;
            byteCnt_d = '0;
            err_d     = 1'b1;
        end else begin
            byteCnt_d = byteCnt_q + CW'(1);
            case (state_q)
                CTRL_HI: begin
                    hi_d    = packetIn;
                    state_d = CTRL_LO;
                end
                CTRL_LO: begin
                    cmd_d   = 2'b01;
                    data_d  = {hi_q, packetIn};
                    rdy_d   = 1'b1;
                    state_d = SKIP;
                end
                AUD_HI: begin
                    hi_d    = packetIn;
                    state_d = AUD_LO;
                end
                AUD_LO: begin
                    cmd_d   = 2'b10;
                    data_d  = {hi_q, packetIn};
                    rdy_d   = 1'b1;
                    state_d = (byteCnt_q == PENULT) ? TRAIL : AUD_HI;
                end
                TRAIL: begin
`ifdef RX_TRAILER_CHECK_EN
                    err_d = (packetIn != 8'hFF);
`endif
                    state_d = IDLE;
                end
                SKIP:    state_d = SKIP;
                default: state_d = IDLE;
            endcase
            if (byteCnt_q == LAST) begin
                state_d   = IDLE;
                byteCnt_d = '0;
                pktEnd_d  = 1'b1;
            end
        end
    end

    // Bridge the IDLE cycle of a back-to-back header so busy does not glitch low.
    assign busy      = (state_q != IDLE) || (pktEnd_q && receiving);
    assign cmd       = cmd_q;
    assign data      = data_q;
    assign dataReady = rdy_q;
    assign error     = err_q;

endmodule

// File: tb/tb_transport_receive.sv
// Bench for transport_receive: packet-level reference model predicts per-cycle outputs
// for directed and random packet streams, including aborts, bad headers and reset.
module tb_transport_receive;
    localparam int PS   = 16;
    localparam int MAXS = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  packetIn;
    logic        receiving;
    logic [1:0]  cmd;
    logic [15:0] data;
    logic        dataReady;
    logic        busy;
    logic        error;

    transport_receive #(.packetSize(PS)) dut (
        .clk(clk), .reset(reset), .packetIn(packetIn), .receiving(receiving),
        .cmd(cmd), .data(data), .dataReady(dataReady), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic        rxq[$];
    logic [7:0]  bq[$];
    logic        edr  [MAXS];
    logic        eerr [MAXS];
    logic        ebusy[MAXS];
    logic        eend [MAXS];
    logic [1:0]  ecmd [MAXS];
    logic [15:0] edata[MAXS];
    logic [1:0]  cur_cmd  = 2'b00;
    logic [15:0] cur_data = 16'h0;
    logic [7:0]  pk[PS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stream();
        rxq.delete();
        bq.delete();
        for (int i = 0; i < MAXS; i++) begin
            edr[i] = 0; eerr[i] = 0; ebusy[i] = 0; eend[i] = 0; ecmd[i] = 0; edata[i] = 0;
        end
    endtask

    // Append a packet of which only the first L bytes are sent, then gap idle cycles,
    // and record what the receiver should do, index = edge at which a byte is sampled.
    task automatic add_packet(input logic [7:0] b[PS], input int L, input int gap_in);
        int p, gap;
        p   = rxq.size();
        gap = (L < PS && gap_in == 0) ? 1 : gap_in;
        for (int i = 0; i < L; i++) begin rxq.push_back(1'b1); bq.push_back(b[i]); end
        for (int g = 0; g < gap; g++) begin rxq.push_back(1'b0); bq.push_back(8'($urandom)); end
        if (b[0] == 8'h40) begin
            if (L >= 3) begin
                edr[p+2] = 1; ecmd[p+2] = 2'b01; edata[p+2] = {b[1], b[2]};
            end
        end else if (b[0] == 8'h81) begin
            for (int k = 0; k < (PS - 2) / 2; k++) begin
                int lo;
                lo = 2 * k + 2;
                if (lo < L) begin
                    edr[p+lo] = 1; ecmd[p+lo] = 2'b10; edata[p+lo] = {b[lo-1], b[lo]};
                end
            end
`ifdef RX_TRAILER_CHECK_EN
            if (L == PS && b[PS-1] != 8'hFF) eerr[p+PS-1] = 1;
`endif
        end else begin
            eerr[p] = 1;
        end
        if (L < PS) begin
            eerr[p+L] = 1;
            for (int i = 0; i < L; i++) ebusy[p+i] = 1;
        end else begin
            for (int i = 0; i < PS - 1; i++) ebusy[p+i] = 1;
            eend[p+PS-1] = 1;
        end
    endtask

    // Play the queued stream; if rst_at >= 0, pulse reset after that cycle and stop.
    task automatic run_stream(input int rst_at);
        int n;
        logic nxt_rx;
        n = rxq.size();
        receiving = rxq[0];
        packetIn  = bq[0];
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            nxt_rx    = (t + 1 < n) ? rxq[t+1] : 1'b0;
            receiving = nxt_rx;
            packetIn  = (t + 1 < n) ? bq[t+1] : 8'h00;
            #1;
            if (edr[t]) begin cur_cmd = ecmd[t]; cur_data = edata[t]; end
            chk("dataReady", dataReady, edr[t]);
            chk("cmd", cmd, cur_cmd);
            chk("data", data, cur_data);
            chk("error", error, eerr[t]);
            chk("busy", busy, eend[t] ? nxt_rx : ebusy[t]);
            if (t == rst_at) begin
                receiving = 1'b0;
                reset = 1'b1;
                #1;
                chk("rst_cmd", cmd, 2'b00);
                chk("rst_data", data, 16'h0);
                chk("rst_dataReady", dataReady, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_error", error, 1'b0);
                cur_cmd = 2'b00; cur_data = 16'h0;
                reset = 1'b0;
                break;
            end
        end
        receiving = 1'b0;
        clear_stream();
    endtask

    task automatic mk_ctrl(input logic [7:0] hi, input logic [7:0] lo);
        pk[0] = 8'h40; pk[1] = hi; pk[2] = lo;
        for (int i = 3; i < PS; i++) pk[i] = 8'h00;
    endtask

    task automatic mk_audio(input logic [7:0] trailer);
        pk[0] = 8'h81;
        for (int k = 0; k < (PS - 2) / 2; k++) begin
            pk[2*k+1] = 8'h00; pk[2*k+2] = 8'(k + 1);
        end
        pk[PS-1] = trailer;
    endtask

    task automatic mk_random();
        int kind;
        kind = $urandom_range(0, 3);
        for (int i = 0; i < PS; i++) pk[i] = 8'($urandom);
        case (kind)
            0: pk[0] = 8'h40;
            1: begin pk[0] = 8'h81; pk[PS-1] = 8'hFF; end
            2: pk[0] = 8'h81;
            default: while (pk[0] == 8'h40 || pk[0] == 8'h81) pk[0] = 8'($urandom);
        endcase
    endtask

    initial begin
        clear_stream();
        reset = 1'b1; receiving = 1'b0; packetIn = 8'h00;
        #12;
        chk("reset_cmd", cmd, 2'b00);
        chk("reset_data", data, 16'h0);
        chk("reset_dataReady", dataReady, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_error", error, 1'b0);
        reset = 1'b0;

        mk_ctrl(8'h12, 8'h34);      add_packet(pk, PS, 2); run_stream(-1);
        mk_audio(8'hFF);            add_packet(pk, PS, 2); run_stream(-1);
        mk_audio(8'h00);            add_packet(pk, PS, 2); run_stream(-1);

        mk_ctrl(8'h00, 8'h00); pk[0] = 8'h55;
        add_packet(pk, PS, 0);
        mk_ctrl(8'h5A, 8'hC3);      add_packet(pk, PS, 2); run_stream(-1);

        mk_audio(8'hFF);            add_packet(pk, 5, 2);
        mk_ctrl(8'hAB, 8'hCD);      add_packet(pk, PS, 2); run_stream(-1);

        mk_ctrl(8'h77, 8'h88);      add_packet(pk, PS, 0);
        mk_audio(8'hFF);            add_packet(pk, PS, 2); run_stream(PS + 6);
        mk_ctrl(8'h9E, 8'h21);      add_packet(pk, PS, 2); run_stream(-1);

        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < 5; j++) begin
                mk_random();
                add_packet(pk, ($urandom_range(0, 3) == 0) ? $urandom_range(1, PS - 1) : PS,
                           $urandom_range(0, 2));
            end
            run_stream(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
